spi_slave: RTL and testbench

- Serial front end for the single-port RAM command interface.
- Deserialises 10-bit SPI frames from MOSI into a parallel command word (rx_data/rx_valid) for the RAM.
- Serialises the RAM's 8-bit read data (tx_data/tx_valid) back onto MISO.
- SPI mode 0, MSB first; clk is the SPI clock. Sits between the pads and the RAM inside the SPI wrapper.

---
 rtl/spi_slave.sv | 91 +++++++++
 tb/tb_spi_slave.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave that frames 10-bit RAM commands from MOSI
// and shifts 8-bit RAM read data back out on MISO, MSB first.
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MOSI,
  input  logic                 SS_n,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);
  localparam int CW = $clog2(ADDR_SIZE + 2);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t               r_state, w_next;
  logic [ADDR_SIZE:0]   r_sh;
  logic [CW-1:0]        r_cnt, r_tx_cnt;
  logic [ADDR_SIZE-1:0] r_tx_sh;
  logic                 r_rd_done, r_load;
  logic                 w_frame_bit, w_last_bit, w_tx_go;

  // r_cnt saturates at ADDR_SIZE+1 once bit 0 is in, so extra bits are ignored
  assign w_frame_bit = (r_state != IDLE) && (r_cnt < CW'(ADDR_SIZE + 1));
  assign w_last_bit  = (r_state != CHK_CMD) && (r_cnt == CW'(ADDR_SIZE));
  assign w_tx_go     = (r_state == READ_DATA) && (r_cnt == CW'(ADDR_SIZE + 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (SS_n)                     w_next = IDLE;
    else if (r_state == IDLE)     w_next = CHK_CMD;
    else if (r_state == CHK_CMD)  w_next = !MOSI ? WRITE : (r_rd_done ? READ_DATA : READ_ADD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_tx_cnt  <= '0;
      r_tx_sh   <= '0;
      r_rd_done <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n) begin
        r_cnt    <= '0;
        r_tx_cnt <= '0;
        r_load   <= 1'b0;
        MISO     <= 1'b0;
      end else begin
        if (w_frame_bit) begin
          r_sh <= {r_sh[ADDR_SIZE-1:0], MOSI};
          if (r_state != CHK_CMD) r_cnt <= r_cnt + 1'b1;
          if (w_last_bit) begin
            rx_data  <= {r_sh, MOSI};
            rx_valid <= 1'b1;
            if (r_state == READ_ADD) r_rd_done <= 1'b1;
          end
        end
        // r_load blocks a held-high tx_valid from reloading the shifter
        if (w_tx_go) begin
          if (!r_load && tx_valid) begin
            r_load   <= 1'b1;
            MISO     <= tx_data[ADDR_SIZE-1];
            r_tx_sh  <= tx_data << 1;
            r_tx_cnt <= CW'(ADDR_SIZE);
          end else if (r_tx_cnt > CW'(1)) begin
            MISO     <= r_tx_sh[ADDR_SIZE-1];
            r_tx_sh  <= r_tx_sh << 1;
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end else if (r_tx_cnt == CW'(1)) begin
            MISO      <= 1'b0;
            r_rd_done <= 1'b0;
            r_tx_cnt  <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed frames; a queue scoreboard checks every rx_valid word,
// MISO and read-address tracking are checked inline.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       MOSI = 1'b0;
  logic       SS_n = 1'b1;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got rx_data %0h expected no rx_valid", rx_data);
      end else
        chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  // E0 then E1..E10; returns just after E10, with whether MISO was ever high
  task automatic send(input logic [9:0] w, output logic miso_seen);
    exp_q.push_back(w);
    miso_seen = 1'b0;
    tick(1'b0, 1'b0);
    for (int i = 9; i >= 0; i--) begin
      tick(1'b0, w[i]);
      miso_seen |= MISO;
    end
  endtask

  initial begin
    logic       seen;
    logic [7:0] exp_b;
    exp_b = 8'hB6;
    #12;
    chk("reset_miso", 32'(MISO), 0);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_rd_done", 32'(dut.r_rd_done), 0);
    @(negedge clk) rst_n = 1'b1;

    send(10'h0A5, seen);
    chk("wr_addr_miso", 32'(seen), 0);
    chk("wr_addr_state", 32'(dut.r_state), 2);
    tick(1'b1, 1'b0);
    send(10'h13C, seen);
    chk("wr_data_miso", 32'(seen), 0);
    tick(1'b1, 1'b0);

    send(10'h2A5, seen);
    tick(1'b1, 1'b0);
    chk("rd_addr_done_set", 32'(dut.r_rd_done), 1);

    send(10'h300, seen);
    chk("rd_data_state", 32'(dut.r_state), 4);
    tick(1'b0, 1'b0);
    chk("rd_e11_miso", 32'(MISO), 0);
    tx_data = 8'hB6;
    tx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("rd_bit%0d", 7 - i), 32'(MISO), 32'(exp_b[7 - i]));
    end
    tick(1'b0, 1'b0);
    chk("rd_e20_miso", 32'(MISO), 0);
    chk("rd_done_cleared", 32'(dut.r_rd_done), 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      seen |= MISO;
    end
    chk("held_tx_no_reload", 32'(seen), 0);
    tx_valid = 1'b0;
    tick(1'b1, 1'b0);

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("abort_state_idle", 32'(dut.r_state), 0);
    chk("abort_rd_done", 32'(dut.r_rd_done), 0);
    chk("abort_miso", 32'(MISO), 0);
    tick(1'b1, 1'b0);

    send(10'h2A5, seen);
    tick(1'b1, 1'b0);
    send(10'h300, seen);
    tick(1'b0, 1'b0);
    tx_data = 8'hB6;
    tx_valid = 1'b1;
    tick(1'b0, 1'b0);
    chk("pre_reset_miso", 32'(MISO), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_miso", 32'(MISO), 0);
    chk("async_rst_rx_valid", 32'(rx_valid), 0);
    chk("async_rst_rx_data", 32'(rx_data), 0);
    chk("async_rst_rd_done", 32'(dut.r_rd_done), 0);
    @(negedge clk) rst_n = 1'b1;
    tick(1'b1, 1'b0);
    send(10'h3FF, seen);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      seen |= MISO;
    end
    chk("post_rst_read_is_addr", 32'(seen), 0);
    chk("post_rst_rd_done", 32'(dut.r_rd_done), 1);
    tx_valid = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
